// File: rtl/fb_pkg.sv
// Shared types and constants for the pixel write path into the 1-bit framebuffer.
package fb_pkg;

  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;

  // Number of bits needed to address every pixel of a WIDTH x HEIGHT screen
  function automatic int calc_addr_w(input int width, input int height);
    return $clog2(width * height);
  endfunction

  // Drain/clear controller states
  typedef enum logic [0:0] {
    DRAIN = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // One buffered pixel write as it arrives from the draw blocks
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        color;
  } pixel_t;

endpackage

// File: rtl/pixel_write_buffer_if.sv
// Pixel stream input, clear control and framebuffer write port of the pixel write buffer.
interface pixel_write_buffer_if #(
  parameter int WIDTH  = fb_pkg::DEFAULT_WIDTH,
  parameter int HEIGHT = fb_pkg::DEFAULT_HEIGHT,
  parameter int ADDR_W = fb_pkg::calc_addr_w(WIDTH, HEIGHT)
);

  logic              in_valid;
  logic              in_ready;
  logic [10:0]       x;
  logic [10:0]       y;
  logic              pixel_color;
  logic              clear_req;
  logic              clear_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wdata;
  logic              mem_we;
  logic [15:0]       drop_count;

  // Producer side: the draw blocks offering pixels and observing the write port
  modport master (
    output in_valid, x, y, pixel_color, clear_req,
    input  in_ready, clear_busy, mem_addr, mem_wdata, mem_we, drop_count
  );

  // Buffer side: accepts pixels and drives the framebuffer write port
  modport slave (
    input  in_valid, x, y, pixel_color, clear_req,
    output in_ready, clear_busy, mem_addr, mem_wdata, mem_we, drop_count
  );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = $bits(pixel_t)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] storage_q [DEPTH];
  logic [DATA_W-1:0] storage_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = storage_q[rd_ptr_q[IDX_W-1:0]];

  // Next storage contents and pointer positions for this cycle's push/pop
  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push) begin
      storage_d[wr_ptr_q[IDX_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Register FIFO state; reset empties the buffer and discards its contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      storage_q <= storage_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers clipped pixel writes and commits them to the framebuffer, with an ordered clear sweep.
module pixel_write_buffer
  import fb_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_write_buffer_if.slave  bus
);

  localparam int                ADDR_W    = calc_addr_w(WIDTH, HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [10:0]       WIDTH_C   = 11'(WIDTH);
  localparam logic [10:0]       HEIGHT_C  = 11'(HEIGHT);

  state_e            state_q, state_d;
  logic              clear_pending_q, clear_pending_d;
  logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  logic              clear_busy;
  logic              accept;
  logic              on_screen;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  pixel_t            fifo_wdata;
  pixel_t            fifo_rdata;
  logic [ADDR_W-1:0] pix_addr;

  assign clear_busy = clear_pending_q || (state_q == CLEAR);
  assign on_screen  = (bus.x < WIDTH_C) && (bus.y < HEIGHT_C);
  assign accept     = bus.in_valid && bus.in_ready;
  assign fifo_push  = accept && on_screen;
  assign fifo_pop   = (state_q == DRAIN) && !fifo_empty;
  assign fifo_wdata = '{x: bus.x, y: bus.y, color: bus.pixel_color};
  assign pix_addr   = (ADDR_W'(fifo_rdata.y) * ADDR_W'(WIDTH)) + ADDR_W'(fifo_rdata.x);

  assign bus.in_ready   = !reset && !fifo_full && !clear_busy;
  assign bus.clear_busy = clear_busy;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.drop_count = drop_count_q;

  pixel_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W ($bits(pixel_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Count off-screen pixels that were accepted and thrown away, saturating at all ones
  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && !on_screen && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Drain queued pixels, then sweep the whole screen once a clear is pending and the queue is dry
  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clear_addr_d    = clear_addr_q;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    if (bus.clear_req && !clear_busy) begin
      clear_pending_d = 1'b1;
    end
    case (state_q)
      DRAIN: begin
        if (fifo_pop) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = pix_addr;
          mem_wdata_d = fifo_rdata.color;
        end else if (clear_pending_q && fifo_empty) begin
          state_d         = CLEAR;
          clear_pending_d = 1'b0;
          clear_addr_d    = '0;
        end
      end
      CLEAR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = clear_addr_q;
        mem_wdata_d = 1'b0;
        if (clear_addr_q == LAST_ADDR) begin
          state_d      = DRAIN;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      default: begin
        state_d = DRAIN;
      end
    endcase
  end

  // Register controller state and the framebuffer write port; reset abandons any write in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= DRAIN;
      clear_pending_q <= 1'b0;
      clear_addr_q    <= '0;
      drop_count_q    <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clear_addr_q    <= clear_addr_d;
      drop_count_q    <= drop_count_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer on an 8x4 screen with a 4-entry FIFO.
module tb_pixel_write_buffer;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int D    = 4;
  localparam int NPIX = W * H;

  typedef struct {
    int addr;
    bit data;
    bit is_clear;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  exp_t expq[$];
  int   checks      = 0;
  int   failures    = 0;
  int   drop_exp    = 0;
  bit   clear_active = 1'b0;
  int   last_clear_addr = -1;

  pixel_write_buffer_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  pixel_write_buffer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the value the bench expects
  task automatic check_output(input string name, input longint actual, input longint required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // Offer one cycle of input, then update the reference model if the edge took it
  task automatic apply_stimulus(input bit v, input int xx, input int yy, input bit c, input bit clr);
    bit rdy;
    @(negedge clk);
    #1;
    bus.in_valid    = v;
    bus.x           = 11'(xx);
    bus.y           = 11'(yy);
    bus.pixel_color = c;
    bus.clear_req   = clr;
    check_output("in_ready", bus.in_ready, !clear_active);
    rdy = bus.in_ready;
    @(posedge clk);
    if (v && rdy) begin
      if (xx < W && yy < H) expq.push_back('{yy * W + xx, c, 1'b0});
      else drop_exp++;
    end
    if (clr && !clear_active) begin
      clear_active = 1'b1;
      for (int i = 0; i < NPIX; i++) expq.push_back('{i, 1'b0, 1'b1});
    end
    #1;
    bus.in_valid  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  // Idle until every expected write has appeared, bounded by a cycle budget
  task automatic wait_drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      apply_stimulus(0, 0, 0, 0, 0);
      n++;
    end
    check_output("drain_timeout_left", expq.size(), 0);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);
  endtask

  // Monitor: every framebuffer write must match the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    bit   last_now;
    if (!reset) begin
      last_now = bus.mem_we && expq.size() > 0 && expq[0].is_clear && expq[0].addr == NPIX - 1;
      if (clear_active && !last_now) begin
        check_output("clear_busy_during_clear", bus.clear_busy, 1);
        check_output("in_ready_during_clear", bus.in_ready, 0);
      end
      if (bus.mem_we) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write actual=addr %0d data %0d required=no write at %0t",
                   bus.mem_addr, bus.mem_wdata, $time);
        end else begin
          e = expq.pop_front();
          check_output("mem_addr", bus.mem_addr, e.addr);
          check_output("mem_wdata", bus.mem_wdata, e.data);
          if (e.is_clear) begin
            last_clear_addr = e.addr;
            if (e.addr == NPIX - 1) begin
              clear_active = 1'b0;
              check_output("clear_busy_after_last", bus.clear_busy, 0);
            end
          end
        end
      end
    end
  end

  // Runaway guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.x           = '0;
    bus.y           = '0;
    bus.pixel_color = 1'b0;
    bus.clear_req   = 1'b0;

    // Reset state
    #12;
    check_output("reset_in_ready", bus.in_ready, 0);
    check_output("reset_mem_we", bus.mem_we, 0);
    check_output("reset_mem_addr", bus.mem_addr, 0);
    check_output("reset_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("release_in_ready", bus.in_ready, 1);
    check_output("release_clear_busy", bus.clear_busy, 0);
    check_output("release_drop_count", bus.drop_count, 0);

    // Single pixel with latency check
    $display("[TB] single pixel");
    apply_stimulus(1, 3, 2, 1, 0);
    @(negedge clk);
    check_output("latency_no_write_yet", bus.mem_we, 0);
    @(negedge clk);
    check_output("latency_write", bus.mem_we, 1);
    check_output("latency_addr", bus.mem_addr, 19);
    wait_drain(20);

    // Burst of six pixels on row 0
    $display("[TB] burst");
    for (int i = 0; i < 6; i++) apply_stimulus(1, i, 0, i[0], 0);
    wait_drain(20);

    // Four back-to-back pixels
    for (int i = 0; i < 4; i++) apply_stimulus(1, 7 - i, 3, 1, 0);
    wait_drain(20);

    // Clipping
    $display("[TB] clipping");
    apply_stimulus(1, 8, 0, 1, 0);
    apply_stimulus(1, 0, 4, 1, 0);
    wait_drain(20);
    check_output("drop_count_clip", bus.drop_count, drop_exp);
    apply_stimulus(1, 7, 3, 1, 0);
    wait_drain(20);

    // Clear ordering, with a repeat request during the sweep that must be ignored
    $display("[TB] clear ordering");
    apply_stimulus(1, 1, 1, 1, 0);
    apply_stimulus(1, 2, 1, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    repeat (10) apply_stimulus(1, 4, 2, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    wait_drain(100);

    // Randomized traffic with occasional clears
    $display("[TB] random");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 9), $urandom_range(0, 5),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
    end
    wait_drain(200);
    check_output("drop_count_random", bus.drop_count, drop_exp);

    // Reset in the middle of a sweep
    $display("[TB] reset mid-sweep");
    apply_stimulus(1, 5, 1, 1, 1);
    n = 0;
    while (last_clear_addr != 12 && n < 100) begin
      apply_stimulus(0, 0, 0, 0, 0);
      n++;
    end
    check_output("reached_clear_addr", last_clear_addr, 12);
    #1;
    reset = 1'b1;
    #1;
    check_output("reset_async_mem_we", bus.mem_we, 0);
    check_output("reset_async_in_ready", bus.in_ready, 0);
    expq.delete();
    clear_active = 1'b0;
    drop_exp     = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("after_reset_clear_busy", bus.clear_busy, 0);
    check_output("after_reset_drop_count", bus.drop_count, 0);
    check_output("after_reset_in_ready", bus.in_ready, 1);
    check_output("after_reset_mem_we", bus.mem_we, 0);
    repeat (5) apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 6, 3, 0, 0);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
